// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// alu_exec_unit: EX-stage ALU. Decodes the main-control op (uc) and the R-type
// funct field, then executes on operands captured at acceptance.
// Single-cycle ops deliver one cycle after acceptance. MULTU runs a shift-add
// loop for WIDTH cycles and produces a 2*WIDTH-bit product.
//
// state | meaning
// IDLE  | ready for a new op (subject to output backpressure)
// MUL   | iterative unsigned multiply in progress, in_ready held low
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       uc,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_ILL
    } op_t;

    state_t           state_q, state_d;
    op_t              op_dec;
    logic [WIDTH-1:0] alu_res;
    logic [SW-1:0]    shamt;
    logic             accept, deliver, mul_last;

    logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign shamt   = b[SW-1:0];
    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // Decode uc/funct into an internal op; anything unrecognised is illegal.
    always_comb begin
        op_dec = OP_ILL;
        case (uc)
            3'b000: op_dec = OP_ADD;
            3'b001: op_dec = OP_SUB;
            3'b010: op_dec = OP_AND;
            3'b011: op_dec = OP_OR;
            3'b100: op_dec = OP_SLT;
            3'b111: begin
                case (funct)
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b100110: op_dec = OP_XOR;
                    6'b100111: op_dec = OP_NOR;
                    6'b101010: op_dec = OP_SLT;
                    6'b101011: op_dec = OP_SLTU;
                    6'b000000: op_dec = OP_SLL;
                    6'b000010: op_dec = OP_SRL;
                    6'b000011: op_dec = OP_SRA;
                    6'b011001: op_dec = MUL_EN ? OP_MULTU : OP_ILL;
                    default:   op_dec = OP_ILL;
                endcase
            end
            default: op_dec = OP_ILL;
        endcase
    end

    // Single-cycle result; illegal and MULTU fall through to zero here.
    always_comb begin
        alu_res = '0;
        case (op_dec)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the low multiplier bit is
    // set, then shift the {carry, hi, lo} product right by one.
    always_comb begin
        step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && op_dec == OP_MULTU) state_d = MUL;
            MUL:     if (mul_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness, busy flag and final-step strobe.
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid || out_ready);
        busy     = (state_q == MUL);
        mul_last = (state_q == MUL) && (cnt_q == CW'(1));
    end

    // Multiply datapath: operands captured on entry, down-counter of steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else if (accept && op_dec == OP_MULTU) begin
            mcand_q  <= a;
            acc_lo_q <= b;
            acc_hi_q <= '0;
            cnt_q    <= CW'(WIDTH);
        end else if (state_q == MUL) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Output registers: load on single-cycle accept or final multiply step,
    // otherwise hold; out_valid drops only when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && op_dec != OP_MULTU) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            result_hi <= '0;
            zero      <= (alu_res == '0);
            illegal   <= (op_dec == OP_ILL);
        end else if (mul_last) begin
            out_valid <= 1'b1;
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= (step_lo == '0);
            illegal   <= 1'b0;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

endmodule
